// File: rtl/fir_mem_pkg.sv
// Shared types for the FIR RAM arbiter slice.
// Write-request bundle and grant encoding.
package fir_mem_pkg;

  localparam int FIR_ADDR_W = 13;
  localparam int FIR_DATA_W = 16;

  typedef struct packed {
    logic [FIR_ADDR_W-1:0] addr;
    logic [FIR_DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } grant_t;

endpackage

// File: rtl/fir_wbuf.sv
// Circular write buffer for AXI-side RAM writes.
// Head entry is visible combinationally; a push is seen one cycle later.
module fir_wbuf
  import fir_mem_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wr_req_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_d,
  input  logic          pop,
  output T              head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= push_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
      if (push && !pop)      r_level <= r_level + 1'b1;
      else if (!push && pop) r_level <= r_level - 1'b1;
    end
  end

  assign head  = r_mem[r_rp];
  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);

endmodule

// File: rtl/fir_ram_arbiter.sv
// Single-port RAM arbiter: buffered AXI writes vs FIR reads.
// Reads win bounded bursts; a full buffer always takes the port.
module fir_ram_arbiter
  import fir_mem_pkg::*;
#(
  parameter int  ADDR_W     = FIR_ADDR_W,
  parameter int  DATA_W     = FIR_DATA_W,
  parameter int  WBUF_DEPTH = 2,
  parameter int  MAX_BURST  = 4,
  parameter int  RD_LAT     = 1,
  localparam int LW         = $clog2(WBUF_DEPTH) + 1
) (
  input  logic              a_clk,
  input  logic              a_rst_n,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_address_wr,
  input  logic [DATA_W-1:0] a_data_out,
  output logic              a_wr_ready,
  input  logic              f_rd_req,
  input  logic [ADDR_W-1:0] f_rd_addr,
  output logic              f_rd_gnt,
  output logic              f_rd_valid,
  output logic [DATA_W-1:0] f_rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [LW-1:0]     wbuf_level,
  output logic              err_drop
);

  localparam int SW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_BURST);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              w_head;
  req_t              w_push_d;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_yield;
  grant_t            w_gnt;
  logic              r_live;
  logic              r_err;
  logic [SW-1:0]     r_streak;
  logic [RD_LAT-1:0] r_vpipe;

  assign a_wr_ready = !w_full;
  assign w_push     = a_wr && a_wr_ready;
  assign w_push_d   = '{addr: a_address_wr, data: a_data_out};

  fir_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .T     (req_t)
  ) u_wbuf (
    .clk    (a_clk),
    .rst_n  (a_rst_n),
    .push   (w_push),
    .push_d (w_push_d),
    .pop    (w_gnt == GNT_WR),
    .head   (w_head),
    .level  (wbuf_level),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Grants are held off until the first edge after reset release.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  assign w_yield = w_full || (r_streak == SMAX);

  always_comb begin
    w_gnt = GNT_NONE;
    if (r_live) begin
      unique case (1'b1)
        f_rd_req && w_empty:              w_gnt = GNT_RD;
        !f_rd_req && !w_empty:            w_gnt = GNT_WR;
        f_rd_req && !w_empty && w_yield:  w_gnt = GNT_WR;
        f_rd_req && !w_empty && !w_yield: w_gnt = GNT_RD;
        default:                          w_gnt = GNT_NONE;
      endcase
    end
  end

  always_comb begin
    ram_en    = (w_gnt != GNT_NONE);
    ram_we    = (w_gnt == GNT_WR);
    f_rd_gnt  = (w_gnt == GNT_RD);
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_gnt == GNT_RD) ram_addr = f_rd_addr;
    if (w_gnt == GNT_WR) begin
      ram_addr  = w_head.addr;
      ram_wdata = w_head.data;
    end
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_streak <= '0;
    end else if (w_gnt == GNT_WR || !f_rd_req) begin
      r_streak <= '0;
    end else if (w_gnt == GNT_RD && !w_empty && r_streak != SMAX) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n)               r_err <= 1'b0;
    else if (a_wr && !a_wr_ready) r_err <= 1'b1;
  end

  assign err_drop = r_err;

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= (w_gnt == GNT_RD);
      for (int i = 1; i < RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
    end
  end

  assign f_rd_valid = r_vpipe[RD_LAT-1];
  assign f_rd_data  = f_rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_fir_ram_arbiter.sv
// Randomised and directed bench for fir_ram_arbiter.
// A queue-based model of the arbitration rules predicts every output.
module tb_fir_ram_arbiter;

  localparam int MB = 4;
  localparam int WD = 2;

  logic        a_clk;
  logic        a_rst_n;
  logic        a_wr;
  logic [12:0] a_address_wr;
  logic [15:0] a_data_out;
  logic        a_wr_ready;
  logic        f_rd_req;
  logic [12:0] f_rd_addr;
  logic        f_rd_gnt;
  logic        f_rd_valid;
  logic [15:0] f_rd_data;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [1:0]  wbuf_level;
  logic        err_drop;

  fir_ram_arbiter dut (
    .a_clk        (a_clk),
    .a_rst_n      (a_rst_n),
    .a_wr         (a_wr),
    .a_address_wr (a_address_wr),
    .a_data_out   (a_data_out),
    .a_wr_ready   (a_wr_ready),
    .f_rd_req     (f_rd_req),
    .f_rd_addr    (f_rd_addr),
    .f_rd_gnt     (f_rd_gnt),
    .f_rd_valid   (f_rd_valid),
    .f_rd_data    (f_rd_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .wbuf_level   (wbuf_level),
    .err_drop     (err_drop)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  function automatic logic [15:0] init_val(input logic [12:0] a);
    if (a == 13'h010) return 16'h1234;
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  logic [15:0] rm [8192];
  bit          rw [8192];

  always @(posedge a_clk) begin
    if (ram_en) begin
      if (ram_we) begin
        rm[ram_addr] <= ram_wdata;
        rw[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= rw[ram_addr] ? rm[ram_addr] : init_val(ram_addr);
      end
    end
  end

  typedef struct {
    logic [12:0] a;
    logic [15:0] d;
  } wq_t;

  wq_t         q[$];
  int          streak;
  bit          err;
  bit          pv;
  logic [15:0] pd;
  logic [15:0] xm [8192];
  bit          xw [8192];
  int          n_chk;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd_exp(input logic [12:0] a);
    return xw[a] ? xm[a] : init_val(a);
  endfunction

  task automatic model_clear();
    q.delete();
    streak = 0;
    err    = 1'b0;
    pv     = 1'b0;
    pd     = '0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_en"},  32'(ram_en),     32'd0);
    chk({tag, "_we"},  32'(ram_we),     32'd0);
    chk({tag, "_gnt"}, 32'(f_rd_gnt),   32'd0);
    chk({tag, "_vld"}, 32'(f_rd_valid), 32'd0);
    chk({tag, "_lvl"}, 32'(wbuf_level), 32'd0);
    chk({tag, "_rdy"}, 32'(a_wr_ready), 32'd1);
    chk({tag, "_err"}, 32'(err_drop),   32'd0);
  endtask

  // One cycle: drive at negedge, compare, then advance the model.
  task automatic step(input bit wr, input logic [12:0] wa,
                      input logic [15:0] wd, input bit rq,
                      input logic [12:0] ra, output bit g);
    int          lvl;
    bit          rdy;
    int          eg;
    logic [12:0] ea;
    logic [15:0] ed;
    @(negedge a_clk);
    a_wr         = wr;
    a_address_wr = wa;
    a_data_out   = wd;
    f_rd_req     = rq;
    f_rd_addr    = ra;
    #1;
    lvl = q.size();
    rdy = (lvl < WD);
    if (rq && lvl == 0)                              eg = 1;
    else if (lvl > 0 && (!rq || lvl == WD || streak == MB)) eg = 2;
    else if (rq)                                     eg = 1;
    else                                             eg = 0;
    ea = '0;
    ed = '0;
    if (eg == 1) ea = ra;
    if (eg == 2) begin
      ea = q[0].a;
      ed = q[0].d;
    end
    chk("rdy",   32'(a_wr_ready), 32'(rdy));
    chk("lvl",   32'(wbuf_level), 32'(lvl));
    chk("err",   32'(err_drop),   32'(err));
    chk("en",    32'(ram_en),     32'(eg != 0));
    chk("we",    32'(ram_we),     32'(eg == 2));
    chk("gnt",   32'(f_rd_gnt),   32'(eg == 1));
    chk("addr",  32'(ram_addr),   32'(ea));
    chk("wdata", 32'(ram_wdata),  32'(ed));
    chk("vld",   32'(f_rd_valid), 32'(pv));
    chk("rdata", 32'(f_rd_data),  32'(pv ? pd : 16'h0));
    if (eg == 2) begin
      xm[q[0].a] = q[0].d;
      xw[q[0].a] = 1'b1;
      void'(q.pop_front());
    end
    if (eg == 2 || !rq) streak = 0;
    else if (eg == 1 && lvl > 0 && streak < MB) streak++;
    if (wr) begin
      if (rdy) q.push_back('{a: wa, d: wd});
      else     err = 1'b1;
    end
    pv = (eg == 1);
    if (eg == 1) pd = rd_exp(ra);
    g = (eg == 1);
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, g);
  endtask

  bit          g;
  bit          hold;
  bit          rq;
  logic [12:0] ra;

  initial begin
    n_chk        = 0;
    n_bad        = 0;
    a_rst_n      = 1'b0;
    a_wr         = 1'b0;
    a_address_wr = '0;
    a_data_out   = '0;
    f_rd_req     = 1'b0;
    f_rd_addr    = '0;
    ram_rdata    = '0;
    model_clear();
    repeat (3) @(negedge a_clk);
    chk_rst("rst0");
    a_rst_n = 1'b1;

    // single buffered write, drained next cycle
    step(1, 13'h00A, 16'hABCD, 0, '0, g);
    idle(2);
    // lone read of preloaded word
    step(0, '0, '0, 1, 13'h010, g);
    idle(2);
    // burst limit with one write pending
    step(1, 13'h020, 16'h5555, 1, 13'h100, g);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 1, 13'(13'h101 + i), g);
    idle(2);
    // overflow: third write dropped, full buffer preempts read
    step(1, 13'h030, 16'h1111, 1, 13'h200, g);
    step(1, 13'h031, 16'h2222, 1, 13'h201, g);
    step(1, 13'h032, 16'h3333, 1, 13'h202, g);
    idle(3);
    // push and pop together at level 1, then read back in order
    step(1, 13'h001, 16'hA001, 0, '0, g);
    step(1, 13'h002, 16'hA002, 0, '0, g);
    idle(2);
    step(0, '0, '0, 1, 13'h001, g);
    step(0, '0, '0, 1, 13'h002, g);
    idle(2);

    // reset with a full buffer and a read in flight
    step(1, 13'h040, 16'hBEEF, 1, 13'h300, g);
    step(1, 13'h041, 16'hCAFE, 1, 13'h301, g);
    @(posedge a_clk);
    #2 a_rst_n = 1'b0;
    #1 chk_rst("rst1");
    repeat (2) begin
      @(negedge a_clk);
      chk_rst("rst2");
    end
    a_wr     = 1'b0;
    f_rd_req = 1'b0;
    a_rst_n  = 1'b1;
    model_clear();
    idle(4);

    // random traffic; FIR holds its request until granted
    hold = 1'b0;
    rq   = 1'b0;
    ra   = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        rq = ($urandom_range(0, 3) != 0);
        ra = 13'($urandom_range(0, 63));
      end
      step(bit'($urandom_range(0, 1)), 13'($urandom_range(0, 63)),
           16'($urandom), rq, ra, g);
      hold = rq && !g;
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_ram_arbiter.md
Name: fir_ram_arbiter

Overview:
Arbitrates the single-port coefficient/sample RAM between two requesters: the AXI slave write path (a_wr, a_address_wr, a_data_out) and the FIR engine read path. AXI writes land in a small write buffer so that the AXI slave is rarely stalled. The FIR engine receives read grants with bounded burst length, and read data returns after a fixed RAM latency. The block sits between the AXI slave, the FIR core and the RAM; it replaces direct slave-to-RAM wiring.

Parameters:
ADDR_W, 13, RAM word-address width
DATA_W, 16, RAM word width
WBUF_DEPTH, 2, write-buffer entries (power of 2, >=2)
MAX_BURST, 4, maximum consecutive FIR read grants while a write is pending (>=1)
RD_LAT, 1, RAM read latency in cycles (>=1)

Ports:
a_clk  in  1  clock, all logic on the rising edge
a_rst_n  in  1  asynchronous active-low reset
a_wr  in  1  AXI-side write strobe, one word per cycle
a_address_wr  in  ADDR_W  AXI-side write address
a_data_out  in  DATA_W  AXI-side write data
a_wr_ready  out  1  write buffer can accept a word this cycle
f_rd_req  in  1  FIR read request, held until granted
f_rd_addr  in  ADDR_W  FIR read address
f_rd_gnt  out  1  read granted this cycle
f_rd_valid  out  1  read data valid, RD_LAT cycles after f_rd_gnt
f_rd_data  out  DATA_W  read data
ram_en  out  1  RAM access this cycle
ram_we  out  1  1 = write, 0 = read
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (synchronous, RD_LAT)
wbuf_level  out  clog2(WBUF_DEPTH)+1  current write-buffer occupancy
err_drop  out  1  sticky flag: a_wr was asserted while a_wr_ready=0

Behaviour:
- Reset (async assert, sync release):
  - buffer emptied; wbuf_level=0; a_wr_ready=1
  - streak counter=0; read-valid pipeline cleared; f_rd_valid=0; err_drop=0
  - ram_en=0; ram_we=0; f_rd_gnt=0
  - Reset mid-burst discards buffered writes and in-flight reads.
- Write buffer: circular FIFO of {addr, data}.
  - a_wr_ready = (level < WBUF_DEPTH), from registered state only.
  - Push when a_wr && a_wr_ready.
  - a_wr && !a_wr_ready: word dropped, err_drop set (cleared only by reset).
  - No bypass: a pushed word is eligible for the RAM the next cycle at the earliest (min write latency 1 cycle).
  - Push and pop in the same cycle: level unchanged.
- Arbitration (combinational from f_rd_req, level>0, streak, full):
  - Neither requester: ram_en=0.
  - Only FIR: grant read.
  - Only buffer non-empty: grant write (pop head).
  - Both, and buffer full: grant write.
  - Both, buffer not full, streak < MAX_BURST: grant read.
  - Both, buffer not full, streak == MAX_BURST: grant write.
- Streak counter:
  - +1 on each read grant made while the buffer is non-empty.
  - Reset to 0 on any write grant, or on a cycle with f_rd_req=0.
  - Saturates at MAX_BURST.
- Read grant: f_rd_gnt=1, ram_en=1, ram_we=0, ram_addr=f_rd_addr.
- Write grant: ram_en=1, ram_we=1, ram_addr/ram_wdata = head entry; read pointer advances at the clock edge.
- Idle cycles: ram_addr and ram_wdata are don't-care, driven 0.
- Read return:
  - RD_LAT-deep shift register of grant flags.
  - f_rd_valid = last stage.
  - f_rd_data = ram_rdata when f_rd_valid, else 0.
  - Back-to-back grants yield back-to-back valids.
- Exactly one RAM access per cycle; a read and a write are never both issued.
- Address wrap: none; addresses pass through unchanged.

Decomposition:
- Package fir_mem_pkg:
  - ADDR_W/DATA_W defaults
  - typedef wr_req_t {addr, data}
  - typedef enum grant_t {GNT_NONE, GNT_RD, GNT_WR}
- Sub-module fir_wbuf: the parameterised circular FIFO (push/pop/level/full/empty).
- Arbiter, streak counter and read-valid pipeline stay in the top.

Test Plan:
1. After reset, single a_wr addr=0x00A data=0xABCD, f_rd_req=0 -> next cycle ram_en=1, ram_we=1, ram_addr=0x00A, ram_wdata=0xABCD; wbuf_level 1->0.
2. f_rd_req=1 addr=0x010 alone, RAM preloaded 0x1234 -> f_rd_gnt that cycle; f_rd_valid=1 with f_rd_data=0x1234 exactly RD_LAT=1 cycle later.
3. FIR requests continuously, one write buffered (level 1), MAX_BURST=4 -> 4 read grants, then 1 write grant, then reads resume; streak returns to 0.
4. a_wr on 3 consecutive cycles with f_rd_req=1 (buffer fills to 2) -> a_wr_ready=0 at full, third word dropped, err_drop=1; write grant preempts the read on the full cycle.
5. Simultaneous push and pop at level 1 -> level stays 1; FIFO order preserved (addresses 0x001, 0x002 written in order).
6. Assert a_rst_n=0 mid-burst with level=2 and a read in flight -> outputs go to reset values immediately; f_rd_valid never pulses; no RAM write after reset release.
